// File: rtl/multicycle_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_pkg                                                       |
// | State encoding, opcode/funct constants and ALU codes for the         |
// | multicycle CPU controller.                                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package multicycle_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXEC_R    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_EXEC_I    = 4'd8,
        ST_I_WB      = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_HALT      = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    localparam logic [1:0] c_SRCB_REG  = 2'd0;
    localparam logic [1:0] c_SRCB_ONE  = 2'd1;
    localparam logic [1:0] c_SRCB_SEXT = 2'd2;
    localparam logic [1:0] c_SRCB_ZEXT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_alu_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_decode                                                           |
// | Maps an R-type funct field to an ALU operation and a legality flag.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_decode
    import multicycle_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control,
    output logic       o_legal
);

    always_comb begin
        o_alu_control = c_ALU_ADD;
        o_legal       = 1'b1;
        case (i_funct)
            c_FN_ADD: o_alu_control = c_ALU_ADD;
            c_FN_SUB: o_alu_control = c_ALU_SUB;
            c_FN_AND: o_alu_control = c_ALU_AND;
            c_FN_OR:  o_alu_control = c_ALU_OR;
            c_FN_SLT: o_alu_control = c_ALU_SLT;
            default:  o_legal       = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_control                                                   |
// | Moore controller sequencing the multicycle CPU datapath.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int          COUNT_WIDTH = 32,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [5:0]             Opcode,
    input  logic [5:0]             Funct,
    output logic                   PC_write,
    output logic                   Branch,
    output logic                   PC_src,
    output logic                   Reg_write,
    output logic                   Mem_to_reg,
    output logic                   Reg_dst,
    output logic                   IorD,
    output logic                   Mem_write,
    output logic                   IR_write,
    output logic                   ALU_src_a,
    output logic [1:0]             ALU_src_b,
    output logic [2:0]             ALU_control,
    output logic [3:0]             State,
    output logic                   Halted,
    output logic                   Illegal,
    output logic [COUNT_WIDTH-1:0] Instr_count
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_illegal;
    logic [COUNT_WIDTH-1:0] r_instr_count;
    logic                   w_set_illegal;
    logic                   w_retire;
    logic [2:0]             w_r_alu;
    logic                   w_funct_legal;

    alu_decode u_alu_decode (
        .i_funct       (Funct),
        .o_alu_control (w_r_alu),
        .o_legal       (w_funct_legal)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state       <= ST_FETCH;
            r_illegal     <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_retire)      r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign w_retire = (r_state == ST_MEM_WB) || (r_state == ST_MEM_WRITE) ||
                      (r_state == ST_R_WB)   || (r_state == ST_I_WB)      ||
                      (r_state == ST_BRANCH);

    always_comb begin
        w_next_state  = r_state;
        w_set_illegal = 1'b0;
        PC_write      = 1'b0;
        Branch        = 1'b0;
        PC_src        = 1'b0;
        Reg_write     = 1'b0;
        Mem_to_reg    = 1'b0;
        Reg_dst       = 1'b0;
        IorD          = 1'b0;
        Mem_write     = 1'b0;
        IR_write      = 1'b0;
        ALU_src_a     = 1'b0;
        ALU_src_b     = c_SRCB_REG;
        ALU_control   = c_ALU_AND;
        Halted        = 1'b0;
        case (r_state)
            ST_FETCH: begin
                IR_write     = 1'b1;
                ALU_src_a    = 1'b1;
                ALU_src_b    = c_SRCB_ONE;
                ALU_control  = c_ALU_ADD;
                PC_write     = 1'b1;
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                ALU_src_a   = 1'b1;
                ALU_src_b   = c_SRCB_SEXT;
                ALU_control = c_ALU_ADD;
                if (Opcode == c_OP_LW || Opcode == c_OP_SW)
                    w_next_state = ST_MEM_ADDR;
                else if (Opcode == c_OP_RTYPE && w_funct_legal)
                    w_next_state = ST_EXEC_R;
                else if (Opcode == c_OP_ADDI || Opcode == c_OP_ANDI || Opcode == c_OP_ORI)
                    w_next_state = ST_EXEC_I;
                else if (Opcode == c_OP_BEQ)
                    w_next_state = ST_BRANCH;
                else if (Opcode == HALT_OPCODE)
                    w_next_state = ST_HALT;
                else begin
                    w_next_state  = ST_HALT;
                    w_set_illegal = 1'b1;
                end
            end
            // Memory states keep the address computation on the ALU so ALU-out is stable.
            ST_MEM_ADDR, ST_MEM_READ, ST_MEM_WRITE: begin
                ALU_src_b   = c_SRCB_SEXT;
                ALU_control = c_ALU_ADD;
                if (r_state == ST_MEM_ADDR)
                    w_next_state = (Opcode == c_OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
                else if (r_state == ST_MEM_READ) begin
                    IorD         = 1'b1;
                    w_next_state = ST_MEM_WB;
                end else begin
                    IorD         = 1'b1;
                    Mem_write    = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_MEM_WB: begin
                Reg_write    = 1'b1;
                Mem_to_reg   = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_EXEC_R, ST_R_WB: begin
                ALU_src_b   = c_SRCB_REG;
                ALU_control = w_r_alu;
                if (r_state == ST_EXEC_R)
                    w_next_state = ST_R_WB;
                else begin
                    Reg_write    = 1'b1;
                    Reg_dst      = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_EXEC_I, ST_I_WB: begin
                if (Opcode == c_OP_ANDI) begin
                    ALU_src_b   = c_SRCB_ZEXT;
                    ALU_control = c_ALU_AND;
                end else if (Opcode == c_OP_ORI) begin
                    ALU_src_b   = c_SRCB_ZEXT;
                    ALU_control = c_ALU_OR;
                end else begin
                    ALU_src_b   = c_SRCB_SEXT;
                    ALU_control = c_ALU_ADD;
                end
                if (r_state == ST_EXEC_I)
                    w_next_state = ST_I_WB;
                else begin
                    Reg_write    = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_BRANCH: begin
                ALU_src_b    = c_SRCB_REG;
                ALU_control  = c_ALU_SUB;
                Branch       = 1'b1;
                PC_src       = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                Halted = 1'b1;
            end
            default: w_next_state = ST_HALT;
        endcase
        // Reset held low quiesces every strobe and select regardless of state.
        if (!Reset) begin
            PC_write    = 1'b0;
            Branch      = 1'b0;
            PC_src      = 1'b0;
            Reg_write   = 1'b0;
            Mem_to_reg  = 1'b0;
            Reg_dst     = 1'b0;
            IorD        = 1'b0;
            Mem_write   = 1'b0;
            IR_write    = 1'b0;
            ALU_src_a   = 1'b0;
            ALU_src_b   = c_SRCB_REG;
            ALU_control = c_ALU_AND;
            Halted      = 1'b0;
        end
    end

    assign State       = r_state;
    assign Illegal     = r_illegal;
    assign Instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multicycle_control                                                |
// | Directed bench for the multicycle controller (COUNT_WIDTH = 4).      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_multicycle_control;
    import multicycle_pkg::*;

    // Control vector: {PC_write,Branch,PC_src}_{Reg_write,Mem_to_reg,Reg_dst}_
    //                 {IorD,Mem_write,IR_write}_{ALU_src_a}_{ALU_src_b}_{ALU_control}
    localparam logic [14:0] c_E_ZERO    = 15'b000_000_000_0_00_000;
    localparam logic [14:0] c_E_FETCH   = 15'b100_000_001_1_01_010;
    localparam logic [14:0] c_E_DECODE  = 15'b000_000_000_1_10_010;
    localparam logic [14:0] c_E_EXR_ADD = 15'b000_000_000_0_00_010;
    localparam logic [14:0] c_E_RWB_ADD = 15'b000_101_000_0_00_010;
    localparam logic [14:0] c_E_MADDR   = 15'b000_000_000_0_10_010;
    localparam logic [14:0] c_E_MREAD   = 15'b000_000_100_0_10_010;
    localparam logic [14:0] c_E_MWB     = 15'b000_110_000_0_00_000;
    localparam logic [14:0] c_E_MWRITE  = 15'b000_000_110_0_10_010;
    localparam logic [14:0] c_E_BRANCH  = 15'b011_000_000_0_00_110;
    localparam logic [14:0] c_E_EXI_ORI = 15'b000_000_000_0_11_001;
    localparam logic [14:0] c_E_IWB_ORI = 15'b000_100_000_0_11_001;
    localparam logic [14:0] c_E_EXI_ADI = 15'b000_000_000_0_10_010;
    localparam logic [14:0] c_E_IWB_ADI = 15'b000_100_000_0_10_010;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       PC_write, Branch, PC_src, Reg_write, Mem_to_reg, Reg_dst;
    logic       IorD, Mem_write, IR_write, ALU_src_a, Halted, Illegal;
    logic [1:0] ALU_src_b;
    logic [2:0] ALU_control;
    logic [3:0] State;
    logic [3:0] Instr_count;
    logic [14:0] w_ctl;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control #(.COUNT_WIDTH(4), .HALT_OPCODE(6'b111111)) dut (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Funct(Funct),
        .PC_write(PC_write), .Branch(Branch), .PC_src(PC_src),
        .Reg_write(Reg_write), .Mem_to_reg(Mem_to_reg), .Reg_dst(Reg_dst),
        .IorD(IorD), .Mem_write(Mem_write), .IR_write(IR_write),
        .ALU_src_a(ALU_src_a), .ALU_src_b(ALU_src_b), .ALU_control(ALU_control),
        .State(State), .Halted(Halted), .Illegal(Illegal), .Instr_count(Instr_count)
    );

    always #5 Clock = ~Clock;

    assign w_ctl = {PC_write, Branch, PC_src, Reg_write, Mem_to_reg, Reg_dst,
                    IorD, Mem_write, IR_write, ALU_src_a, ALU_src_b, ALU_control};

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] exp_state, input logic [14:0] exp_ctl);
        chk({tag, ".state"}, 32'(State), 32'(exp_state));
        chk({tag, ".ctl"}, 32'(w_ctl), 32'(exp_ctl));
        chk({tag, ".halted"}, 32'(Halted), 32'(exp_state == 4'(ST_HALT)));
    endtask

    initial begin
        Reset  = 1'b0;
        Opcode = c_OP_RTYPE;
        Funct  = c_FN_ADD;
        step();
        step();
        chk_st("rst", 4'(ST_FETCH), c_E_ZERO);
        chk("rst.count", 32'(Instr_count), 32'd0);
        chk("rst.illegal", 32'(Illegal), 32'd0);
        Reset = 1'b1;
        #1;
        chk_st("r.fetch", 4'(ST_FETCH), c_E_FETCH);
        step(); chk_st("r.decode", 4'(ST_DECODE), c_E_DECODE);
        step(); chk_st("r.exec", 4'(ST_EXEC_R), c_E_EXR_ADD);
        step(); chk_st("r.wb", 4'(ST_R_WB), c_E_RWB_ADD);
        step(); chk_st("r.done", 4'(ST_FETCH), c_E_FETCH);
        chk("r.count", 32'(Instr_count), 32'd1);

        Opcode = c_OP_LW;
        step(); chk_st("lw.decode", 4'(ST_DECODE), c_E_DECODE);
        step(); chk_st("lw.addr", 4'(ST_MEM_ADDR), c_E_MADDR);
        step(); chk_st("lw.read", 4'(ST_MEM_READ), c_E_MREAD);
        step(); chk_st("lw.wb", 4'(ST_MEM_WB), c_E_MWB);
        step(); chk_st("lw.done", 4'(ST_FETCH), c_E_FETCH);
        chk("lw.count", 32'(Instr_count), 32'd2);

        Opcode = c_OP_SW;
        step(); chk_st("sw.decode", 4'(ST_DECODE), c_E_DECODE);
        step(); chk_st("sw.addr", 4'(ST_MEM_ADDR), c_E_MADDR);
        step(); chk_st("sw.write", 4'(ST_MEM_WRITE), c_E_MWRITE);
        step(); chk_st("sw.done", 4'(ST_FETCH), c_E_FETCH);
        chk("sw.count", 32'(Instr_count), 32'd3);

        Opcode = c_OP_BEQ;
        step(); chk_st("beq.decode", 4'(ST_DECODE), c_E_DECODE);
        step(); chk_st("beq.branch", 4'(ST_BRANCH), c_E_BRANCH);
        step(); chk_st("beq.done", 4'(ST_FETCH), c_E_FETCH);
        chk("beq.count", 32'(Instr_count), 32'd4);

        Opcode = c_OP_ORI;
        step(); chk_st("ori.decode", 4'(ST_DECODE), c_E_DECODE);
        step(); chk_st("ori.exec", 4'(ST_EXEC_I), c_E_EXI_ORI);
        step(); chk_st("ori.wb", 4'(ST_I_WB), c_E_IWB_ORI);
        step(); chk_st("ori.done", 4'(ST_FETCH), c_E_FETCH);

        Opcode = c_OP_ADDI;
        step(); chk_st("addi.decode", 4'(ST_DECODE), c_E_DECODE);
        step(); chk_st("addi.exec", 4'(ST_EXEC_I), c_E_EXI_ADI);
        step(); chk_st("addi.wb", 4'(ST_I_WB), c_E_IWB_ADI);
        step(); chk_st("addi.done", 4'(ST_FETCH), c_E_FETCH);
        chk("addi.count", 32'(Instr_count), 32'd6);

        Opcode = 6'b010101;
        step(); chk_st("ill.decode", 4'(ST_DECODE), c_E_DECODE);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_st("ill.halt", 4'(ST_HALT), c_E_ZERO);
            chk("ill.flag", 32'(Illegal), 32'd1);
        end
        chk("ill.count", 32'(Instr_count), 32'd6);
        Reset = 1'b0;
        step();
        chk_st("ill.rst", 4'(ST_FETCH), c_E_ZERO);
        chk("ill.rst.flag", 32'(Illegal), 32'd0);
        chk("ill.rst.count", 32'(Instr_count), 32'd0);
        Reset = 1'b1;
        #1;
        chk_st("ill.refetch", 4'(ST_FETCH), c_E_FETCH);

        Opcode = c_OP_LW;
        step(); step(); step();
        step(); chk_st("abort.wb", 4'(ST_MEM_WB), c_E_MWB);
        Reset = 1'b0;
        #1;
        chk_st("abort.hold", 4'(ST_MEM_WB), c_E_ZERO);
        step();
        chk_st("abort.after", 4'(ST_FETCH), c_E_ZERO);
        chk("abort.count", 32'(Instr_count), 32'd0);
        Reset = 1'b1;

        Opcode = c_OP_BEQ;
        for (int i = 0; i < 17; i++) begin
            step(); step(); step();
            if (i == 15) chk("wrap.16", 32'(Instr_count), 32'd0);
        end
        chk_st("wrap.state", 4'(ST_FETCH), c_E_FETCH);
        chk("wrap.17", 32'(Instr_count), 32'd1);

        Opcode = 6'b111111;
        step(); step();
        chk_st("hlt.halt", 4'(ST_HALT), c_E_ZERO);
        chk("hlt.flag", 32'(Illegal), 32'd0);
        chk("hlt.count", 32'(Instr_count), 32'd1);

        Reset = 1'b0;
        step();
        Reset  = 1'b1;
        Opcode = c_OP_RTYPE;
        Funct  = 6'b000000;
        step(); step();
        chk_st("badfn.halt", 4'(ST_HALT), c_E_ZERO);
        chk("badfn.flag", 32'(Illegal), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
